// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/ack handshake between the fetch stage and imem.
interface fetch_unit_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from variable-latency imem, holds words across stalls
// and applies ID redirects, inserting bubbles via IF_flush instead of freezing.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PC_write,
    input  logic               dmem_stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        PC_4,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic               IF_flush,
    output logic [31:0]        bubble_cnt
);
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;
    state_t      state;
    logic [31:0] pc, hold_buf, redir_pc, tgt;
    logic        slot;
    assign slot            = PC_write && !dmem_stall;
    assign tgt             = redirect_pc & 32'hFFFF_FFFC;
    assign imem.imem_req   = !rst && state != S_HOLD;
    assign imem.imem_addr  = pc[31:2];
    assign PC_4            = pc + 32'd4;
    assign inst_valid      = !rst && (state == S_HOLD || (state == S_REQ && imem.imem_ack));
    assign inst            = rst ? '0 : state == S_HOLD ? hold_buf : imem.imem_rdata;
    assign IF_flush        = !rst && (redirect || !inst_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= S_REQ;
            hold_buf   <= '0;
            redir_pc   <= '0;
            bubble_cnt <= '0;
        end else begin
            if (slot && !inst_valid)
                bubble_cnt <= bubble_cnt + 32'd1;
            case (state)
                S_REQ:
                    if (slot && redirect && imem.imem_ack)
                        pc <= tgt;
                    else if (slot && redirect) begin
                        redir_pc <= tgt;
                        state    <= S_DROP;
                    end else if (slot && imem.imem_ack)
                        pc <= PC_4;
                    else if (!slot && imem.imem_ack) begin
                        hold_buf <= imem.imem_rdata;
                        state    <= S_HOLD;
                    end
                S_HOLD:
                    if (slot) begin
                        pc    <= redirect ? tgt : PC_4;
                        state <= S_REQ;
                    end
                default: begin
                    // outstanding request cannot be aborted; the latest redirect wins once it lands
                    if (slot && redirect)
                        redir_pc <= tgt;
                    if (imem.imem_ack) begin
                        pc    <= (slot && redirect) ? tgt : redir_pc;
                        state <= S_REQ;
                    end
                end
            endcase
        end
    end
endmodule
